axi_strb_chunker: RTL and testbench

//  Parametrised AXI write-strobe splitter: turns one W beat (strobe + address + tag) into a

---
 rtl/axi_strb_chunker.sv | 194 +++++++++++++++++++
 tb/tb_axi_strb_chunker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_strb_chunker.sv
// -----------------------------------------------------------------------------
// axi_strb_chunker
//
// Splits one AXI W beat into P-Mesh store requests. The beat arrives as a
// strobe, an address and a tag. Each request is a naturally aligned block of
// 2^k bytes, no larger than MAX_CHUNK. Requests leave in ascending byte
// offset. Their masks are disjoint, and together they cover exactly the
// strobe. A beat with an all-zero strobe produces no request.
//
// Parameters
//   STRB_W     bytes per beat (power of two, 2..64)
//   MAX_CHUNK  largest request in bytes (power of two, 1..STRB_W)
//   ADDR_W     byte-address width
//   TAG_W      opaque tag width, copied onto every request of the beat
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   s_valid    in   input beat valid
//   s_ready    out  input beat ready (high only in IDLE and outside reset)
//   s_strb     in   byte strobe, bit i = byte i of the beat
//   s_addr     in   beat address, low log2(STRB_W) bits ignored
//   s_tag      in   beat tag
//   m_valid    out  request valid
//   m_ready    in   request ready
//   m_size     out  size code, 001=1B .. 111=64B
//   m_addr     out  beat base address with the chunk byte offset appended
//   m_mask     out  bytes covered by this request
//   m_tag      out  copy of the beat tag
//   m_last     out  final request of the current beat
// -----------------------------------------------------------------------------
module axi_strb_chunker #(
  parameter int STRB_W    = 8,
  parameter int MAX_CHUNK = 8,
  parameter int ADDR_W    = 40,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [STRB_W-1:0] s_strb,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [TAG_W-1:0]  s_tag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [STRB_W-1:0] m_mask,
  output logic [TAG_W-1:0]  m_tag,
  output logic              m_last
);

  localparam int OFF_W = $clog2(STRB_W);
  localparam int K_MAX = $clog2(MAX_CHUNK);

  // Reject parameter sets that the chunk search cannot handle.
  if ((STRB_W < 2) || (STRB_W > 64) || ((STRB_W & (STRB_W - 1)) != 0)) begin : g_bad_strb
    $error("axi_strb_chunker: STRB_W must be a power of two in 2..64");
  end
  if ((MAX_CHUNK < 1) || (MAX_CHUNK > STRB_W) || ((MAX_CHUNK & (MAX_CHUNK - 1)) != 0)) begin : g_bad_chunk
    $error("axi_strb_chunker: MAX_CHUNK must be a power of two in 1..STRB_W");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t                     state;
  state_t                     state_d;
  logic [STRB_W-1:0]          rem;
  logic [ADDR_W-OFF_W-1:0]    base_hi;
  logic [TAG_W-1:0]           tag_q;

  logic                       accept;
  logic                       load;
  logic [OFF_W-1:0]           low_idx;
  logic [STRB_W-1:0]          chunk_mask;
  logic [2:0]                 chunk_k;
  logic [STRB_W-1:0]          rem_next;
  logic                       rem_empty;

  // The byte-offset bits of the incoming address are replaced by the chunk
  // offset, so they are never used.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^s_addr[OFF_W-1:0];

  assign s_ready   = (state == IDLE) && !rst;
  assign accept    = s_valid && s_ready;
  assign rem_empty = (rem == '0);

  // The output register may take a new chunk when it is empty or is being
  // drained in this same cycle.
  assign load = (state == SPLIT) && !rem_empty && (!m_valid || m_ready);

  assign rem_next = rem & ~chunk_mask;

  // Index of the lowest remaining strobe bit. Scanning from the top down
  // lets the lowest set bit win.
  always_comb begin
    low_idx = '0;
    for (int j = STRB_W - 1; j >= 0; j--) begin
      if (rem[j]) begin
        low_idx = OFF_W'(j);
      end
    end
  end

  // Try every block size from 1 byte up to MAX_CHUNK. A size qualifies when
  // the start offset is aligned to it and every byte it covers is still
  // pending. A larger qualifying size overrides a smaller one. Alignment
  // guarantees that the block stays inside the beat.
  always_comb begin
    logic [STRB_W-1:0] cand;
    cand       = '0;
    chunk_mask = '0;
    chunk_k    = '0;
    for (int k = 0; k <= K_MAX; k++) begin
      cand = ({STRB_W{1'b1}} >> (STRB_W - (1 << k))) << low_idx;
      if (((low_idx & OFF_W'((1 << k) - 1)) == '0) && ((rem & cand) == cand)) begin
        chunk_mask = cand;
        chunk_k    = 3'(k);
      end
    end
  end

  // Next-state logic. A zero-strobe beat falls straight back to IDLE.
  // Otherwise SPLIT exits when the chunk that empties rem is loaded.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        if (rem_empty) begin
          state_d = IDLE;
        end else if (load && (rem_next == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Beat capture and remaining-strobe bookkeeping. accept and load are never
  // true together because they belong to different states.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      base_hi <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      rem     <= s_strb;
      base_hi <= s_addr[ADDR_W-1:OFF_W];
      tag_q   <= s_tag;
    end else if (load) begin
      rem     <= rem_next;
    end
  end

  // Output register. It holds its contents while stalled. It clears valid
  // only on a handshake that has no replacement chunk behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_mask  <= '0;
      m_tag   <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_last  <= (rem_next == '0);
      m_size  <= chunk_k + 3'd1;
      m_addr  <= {base_hi, low_idx};
      m_mask  <= chunk_mask;
      m_tag   <= tag_q;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_strb_chunker.sv
// -----------------------------------------------------------------------------
// tb_axi_strb_chunker
//
// Directed bench for axi_strb_chunker. It uses an 8-byte-beat instance for
// most scenarios and a 16-byte-beat instance for the wide-beat case. Every
// expected chunk is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_axi_strb_chunker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_strb = '0;
  logic [39:0] s_addr = '0;
  logic [3:0]  s_tag = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [2:0]  m_size;
  logic [39:0] m_addr;
  logic [7:0]  m_mask;
  logic [3:0]  m_tag;
  logic        m_last;

  logic        w_s_valid = 1'b0;
  logic        w_s_ready;
  logic [15:0] w_s_strb = '0;
  logic [39:0] w_s_addr = '0;
  logic [3:0]  w_s_tag = '0;
  logic        w_m_valid;
  logic        w_m_ready = 1'b1;
  logic [2:0]  w_m_size;
  logic [39:0] w_m_addr;
  logic [15:0] w_m_mask;
  logic [3:0]  w_m_tag;
  logic        w_m_last;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  axi_strb_chunker #(
    .STRB_W(8), .MAX_CHUNK(8), .ADDR_W(40), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_strb(s_strb),
    .s_addr(s_addr), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_size(m_size),
    .m_addr(m_addr), .m_mask(m_mask), .m_tag(m_tag), .m_last(m_last)
  );

  axi_strb_chunker #(
    .STRB_W(16), .MAX_CHUNK(8), .ADDR_W(40), .TAG_W(4)
  ) dut16 (
    .clk(clk), .rst(rst),
    .s_valid(w_s_valid), .s_ready(w_s_ready), .s_strb(w_s_strb),
    .s_addr(w_s_addr), .s_tag(w_s_tag),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_size(w_m_size),
    .m_addr(w_m_addr), .m_mask(w_m_mask), .m_tag(w_m_tag), .m_last(w_m_last)
  );

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, observed, expected, $time);
    end
  endtask

  // Called at a negedge. Offers a beat, waits (bounded) for acceptance, and
  // returns at the negedge of the cycle after the accepting edge.
  task automatic applyStimulus(input logic [7:0] strb, input logic [39:0] addr,
                               input logic [3:0] tag);
    int n = 0;
    s_valid = 1'b1;
    s_strb  = strb;
    s_addr  = addr;
    s_tag   = tag;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Waits (bounded) for a chunk, checks every field, and advances one cycle
  // so that the handshake (m_ready high) completes.
  task automatic expectChunk(input string name, input int budget,
                             input logic [2:0] size, input logic [39:0] addr,
                             input logic [7:0] mask, input logic [3:0] tag,
                             input logic last);
    int n = 0;
    while (!m_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid"}, 64'(m_valid), 64'd1);
    checkOutput({name, "_size"},  64'(m_size),  64'(size));
    checkOutput({name, "_addr"},  64'(m_addr),  64'(addr));
    checkOutput({name, "_mask"},  64'(m_mask),  64'(mask));
    checkOutput({name, "_tag"},   64'(m_tag),   64'(tag));
    checkOutput({name, "_last"},  64'(m_last),  64'(last));
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_size",  64'(m_size),  64'd0);
    checkOutput("rst_m_addr",  64'(m_addr),  64'd0);
    checkOutput("rst_m_mask",  64'(m_mask),  64'd0);
    checkOutput("rst_m_last",  64'(m_last),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(s_ready), 64'd1);

    // Full strobe: one 8-byte chunk, first valid two cycles after accept.
    $display("[TB] full strobe");
    applyStimulus(8'hFF, 40'h10_00, 4'h5);
    checkOutput("t1_latency_n1", 64'(m_valid), 64'd0);
    @(negedge clk);
    expectChunk("t1_c0", 0, 3'b100, 40'h1000, 8'hFF, 4'h5, 1'b1);
    checkOutput("t1_drained", 64'(m_valid), 64'd0);
    checkOutput("t1_ready_back", 64'(s_ready), 64'd1);

    // Sparse strobe with unaligned start. The address low bits are ignored.
    $display("[TB] strobe 7E");
    applyStimulus(8'h7E, 40'h123F, 4'hA);
    expectChunk("t2_c0", 4, 3'b001, 40'h1239, 8'h02, 4'hA, 1'b0);
    expectChunk("t2_c1", 0, 3'b010, 40'h123A, 8'h0C, 4'hA, 1'b0);
    expectChunk("t2_c2", 0, 3'b010, 40'h123C, 8'h30, 4'hA, 1'b0);
    expectChunk("t2_c3", 0, 3'b001, 40'h123E, 8'h40, 4'hA, 1'b1);
    checkOutput("t2_drained", 64'(m_valid), 64'd0);

    // Zero strobe: dropped silently, ready returns two cycles after accept.
    $display("[TB] zero strobe");
    applyStimulus(8'h00, 40'h2000, 4'h3);
    checkOutput("t3_ready_n1", 64'(s_ready), 64'd0);
    checkOutput("t3_valid_n1", 64'(m_valid), 64'd0);
    @(negedge clk);
    checkOutput("t3_ready_n2", 64'(s_ready), 64'd1);
    checkOutput("t3_valid_n2", 64'(m_valid), 64'd0);
    applyStimulus(8'h03, 40'h0040, 4'h6);
    expectChunk("t3_next", 4, 3'b010, 40'h0040, 8'h03, 4'h6, 1'b1);

    // Backpressure: the chunk must stay stable until the handshake.
    $display("[TB] backpressure");
    m_ready = 1'b0;
    applyStimulus(8'h0F, 40'h0080, 4'hC);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t4_hold_valid", 64'(m_valid), 64'd1);
      checkOutput("t4_hold_mask",  64'(m_mask),  64'h0F);
      checkOutput("t4_hold_size",  64'(m_size),  64'd3);
      checkOutput("t4_hold_addr",  64'(m_addr),  64'h0080);
      checkOutput("t4_hold_last",  64'(m_last),  64'd1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_released", 64'(m_valid), 64'd0);

    // Wide beat, 16 bytes split at the 8-byte boundary.
    $display("[TB] 16-byte beat");
    w_s_valid = 1'b1;
    w_s_strb  = 16'hFFFF;
    w_s_addr  = 40'h2030;
    w_s_tag   = 4'h9;
    checkOutput("t5_ready", 64'(w_s_ready), 64'd1);
    @(negedge clk);
    w_s_valid = 1'b0;
    checkOutput("t5_latency_n1", 64'(w_m_valid), 64'd0);
    @(negedge clk);
    checkOutput("t5_c0_valid", 64'(w_m_valid), 64'd1);
    checkOutput("t5_c0_size",  64'(w_m_size),  64'd4);
    checkOutput("t5_c0_addr",  64'(w_m_addr),  64'h2030);
    checkOutput("t5_c0_mask",  64'(w_m_mask),  64'h00FF);
    checkOutput("t5_c0_last",  64'(w_m_last),  64'd0);
    @(negedge clk);
    checkOutput("t5_c1_valid", 64'(w_m_valid), 64'd1);
    checkOutput("t5_c1_size",  64'(w_m_size),  64'd4);
    checkOutput("t5_c1_addr",  64'(w_m_addr),  64'h2038);
    checkOutput("t5_c1_mask",  64'(w_m_mask),  64'hFF00);
    checkOutput("t5_c1_tag",   64'(w_m_tag),   64'h9);
    checkOutput("t5_c1_last",  64'(w_m_last),  64'd1);
    @(negedge clk);
    checkOutput("t5_drained", 64'(w_m_valid), 64'd0);

    // Reset in the middle of a split discards the pending chunks.
    $display("[TB] reset mid-split");
    applyStimulus(8'h7E, 40'h1238, 4'h2);
    expectChunk("t6_c0", 4, 3'b001, 40'h1239, 8'h02, 4'h2, 1'b0);
    expectChunk("t6_c1", 0, 3'b010, 40'h123A, 8'h0C, 4'h2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_valid", 64'(m_valid), 64'd0);
    checkOutput("t6_rst_mask",  64'(m_mask),  64'd0);
    checkOutput("t6_rst_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_ready_after", 64'(s_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t6_no_chunks", 64'(m_valid), 64'd0);
      @(negedge clk);
    end
    applyStimulus(8'h80, 40'h3000, 4'h7);
    expectChunk("t6_new", 4, 3'b001, 40'h3007, 8'h80, 4'h7, 1'b1);
    checkOutput("t6_drained", 64'(m_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
